// File: rtl/gray_counter_if.sv
// Bundles the count enable and the registered count outputs of gray_counter.
// The counter takes the master side; the consumer/driver of enable takes the slave side.
interface gray_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] gray_count;
    logic [WIDTH-1:0] binary_count;
    logic             terminal;

    modport master (
        input  enable,
        output gray_count,
        output binary_count,
        output terminal
    );

    modport slave (
        output enable,
        input  gray_count,
        input  binary_count,
        input  terminal
    );
endinterface

// File: rtl/gray_counter.sv
// Enable-gated binary-reflected Gray up-counter; Gray, binary and terminal-count
// outputs all come straight from flops so exactly one Gray bit toggles per step.
module gray_counter #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    gray_counter_if.master bus
);

    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_width_check
        $error("gray_counter: WIDTH must be within 2..32");
    end

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             term_q, term_d;

    // Next-state: Gray and terminal are derived from the next binary value so
    // they land on the same edge as the binary count.
    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        term_d = term_q;
        if (bus.enable) begin
            bin_d  = bin_q + ONE;
            gray_d = bin2gray(bin_d);
            term_d = (bin_d == ALL_ONES);
        end else begin
            bin_d  = bin_q;
            gray_d = gray_q;
            term_d = term_q;
        end
    end

    // State registers with synchronous active-low reset taking priority over enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bin_q  <= ZERO;
            gray_q <= ZERO;
            term_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            term_q <= term_d;
        end
    end

    assign bus.gray_count   = gray_q;
    assign bus.binary_count = bin_q;
    assign bus.terminal     = term_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: table-driven WIDTH=5 sequence plus hand-written
// wrap, hold, mid-count reset and WIDTH=2/8 sweep sequences.
module tb_gray_counter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    gray_counter_if #(.WIDTH(5)) if5 ();
    gray_counter_if #(.WIDTH(2)) if2 ();
    gray_counter_if #(.WIDTH(8)) if8 ();

    gray_counter #(.WIDTH(5)) dut5 (.clk(clk), .reset(reset), .bus(if5));
    gray_counter #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    gray_counter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [4:0] exp_gray;
        logic [4:0] exp_bin;
        logic       exp_term;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        int unsigned gseq[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 24};
        logic [4:0]  prev;
        logic [7:0]  m8;
        logic [1:0]  m2;

        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        if5.enable  = 1'b0;
        if2.enable  = 1'b0;
        if8.enable  = 1'b0;

        // Table: reset with enable high, 16 counting steps, then one held edge.
        vecs[0] = '{rst: 1'b0, en: 1'b1, exp_gray: 5'd0, exp_bin: 5'd0, exp_term: 1'b0};
        for (int i = 0; i < 16; i++) begin
            vecs[i+1] = '{rst: 1'b1, en: 1'b1, exp_gray: 5'(gseq[i]), exp_bin: 5'(i + 1), exp_term: 1'b0};
        end
        vecs[17] = '{rst: 1'b1, en: 1'b0, exp_gray: 5'd24, exp_bin: 5'd16, exp_term: 1'b0};

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            reset      = vecs[i].rst;
            if5.enable = vecs[i].en;
            step();
            check($sformatf("tbl%0d_gray", i), 32'(if5.gray_count),   32'(vecs[i].exp_gray));
            check($sformatf("tbl%0d_bin",  i), 32'(if5.binary_count), 32'(vecs[i].exp_bin));
            check($sformatf("tbl%0d_term", i), 32'(if5.terminal),     32'(vecs[i].exp_term));
        end

        // Full wrap over 32 enabled edges.
        if5.enable = 1'b1;
        do_reset();
        prev = if5.gray_count;
        for (int k = 1; k <= 32; k++) begin
            step();
            check($sformatf("wrap%0d_hamming", k), 32'($countones(prev ^ if5.gray_count)), 32'd1);
            check($sformatf("wrap%0d_bin", k), 32'(if5.binary_count), 32'(k % 32));
            check($sformatf("wrap%0d_term", k), 32'(if5.terminal), (k == 31) ? 32'd1 : 32'd0);
            if (k == 31) check("wrap31_gray", 32'(if5.gray_count), 32'd16);
            if (k == 32) check("wrap32_gray", 32'(if5.gray_count), 32'd0);
            prev = if5.gray_count;
        end

        // Hold at Gray 6 for five edges, then resume to 7.
        if5.enable = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check("hold_start_gray", 32'(if5.gray_count), 32'd6);
        if5.enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold%0d_gray", k), 32'(if5.gray_count), 32'd6);
        end
        if5.enable = 1'b1;
        step();
        check("hold_resume_gray", 32'(if5.gray_count), 32'd7);

        // Reset mid-count at Gray 13 with enable still high.
        do_reset();
        for (int k = 0; k < 9; k++) step();
        check("mid_pre_gray", 32'(if5.gray_count), 32'd13);
        reset = 1'b0;
        step();
        check("mid_rst_gray", 32'(if5.gray_count), 32'd0);
        check("mid_rst_term", 32'(if5.terminal),   32'd0);
        reset = 1'b1;
        step();
        check("mid_post_gray", 32'(if5.gray_count), 32'd1);
        if5.enable = 1'b0;

        // Width sweep: WIDTH=2 and WIDTH=8 run side by side from reset.
        if2.enable = 1'b1;
        if8.enable = 1'b1;
        do_reset();
        check("sw_rst_gray2", 32'(if2.gray_count), 32'd0);
        check("sw_rst_gray8", 32'(if8.gray_count), 32'd0);
        m2 = 2'd0;
        m8 = 8'd0;
        for (int k = 1; k <= 256; k++) begin
            step();
            m2 = m2 + 2'd1;
            m8 = m8 + 8'd1;
            check($sformatf("sw%0d_bin8", k),  32'(if8.binary_count), 32'(m8));
            check($sformatf("sw%0d_gray8", k), 32'(if8.gray_count),   32'(m8 ^ (m8 >> 1)));
            check($sformatf("sw%0d_term8", k), 32'(if8.terminal),     (m8 == 8'hFF) ? 32'd1 : 32'd0);
            check($sformatf("sw%0d_bin2", k),  32'(if2.binary_count), 32'(m2));
            check($sformatf("sw%0d_gray2", k), 32'(if2.gray_count),   32'(m2 ^ (m2 >> 1)));
            check($sformatf("sw%0d_term2", k), 32'(if2.terminal),     (m2 == 2'b11) ? 32'd1 : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
